// File: rtl/acq_scheduler.sv
// CCD acquisition sequencer: integration, ROG transfer, pixel readout and FIFO drain.
// Arbitrates sw/hw requests with a single pending slot.
module acq_scheduler #(
    parameter int PIXELS     = 2086,
    parameter int CCD_DIV    = 10,
    parameter int ROG_CYCLES = 8,
    parameter int INT_UNIT   = 24
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req_sw,
    input  logic        req_hw,
    input  logic [15:0] int_time,
    input  logic        fifo_empty,
    output logic        busy,
    output logic        acq_src,
    output logic        strobe_en,
    output logic        ccd_clk,
    output logic        ccd_rog,
    output logic        adc_restart,
    output logic        adc_start,
    output logic        frame_done,
    output logic        req_lost
);

    localparam int IW  = 16 + $clog2(INT_UNIT);
    localparam int RW  = $clog2(PIXELS * CCD_DIV + 1);
    localparam int GW  = $clog2(ROG_CYCLES + 1);
    localparam int CW0 = (IW > RW) ? IW : RW;
    localparam int CW  = (CW0 > GW) ? CW0 : GW;
    localparam int DW  = $clog2(CCD_DIV);

    localparam logic [CW-1:0] READ_LEN = CW'(PIXELS * CCD_DIV - 1);
    localparam logic [CW-1:0] ROG_LEN  = CW'(ROG_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CCD_DIV - 1);
    localparam logic [DW-1:0] HALF     = DW'(CCD_DIV / 2);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INTEG = 3'd1;
    localparam logic [2:0] S_ROG   = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          pend_q, pend_d;
    logic          psrc_q, psrc_d;
    logic          src_q, src_d;
    logic          busy_q, busy_d;
    logic          strobe_q, strobe_d;
    logic          clk_q, clk_d;
    logic          rog_q, rog_d;
    logic          start_q, start_d;
    logic          restart_q, restart_d;
    logic          lost_q, lost_d;

    logic [15:0]   it_eff;
    logic [CW-1:0] integ_len;
    logic [DW-1:0] div_next;
    logic          req_any;
    logic          cnt_zero;
    logic          done;

    always_comb begin
        it_eff    = (int_time == 16'd0) ? 16'd1 : int_time;
        integ_len = CW'(it_eff) * CW'(INT_UNIT) - CW'(1);
        req_any   = req_sw | req_hw;
        cnt_zero  = (cnt_q == '0);
        div_next  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);

        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pend_d  = pend_q;
        psrc_d  = psrc_q;
        src_d   = src_q;
        lost_d  = 1'b0;
        done    = 1'b0;

        // Requests while a frame runs fill the single pending slot or are dropped.
        if (state_q != S_IDLE && req_any) begin
            if (pend_q) begin
                lost_d = 1'b1;
            end else begin
                pend_d = 1'b1;
                psrc_d = req_hw;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    state_d = S_INTEG;
                    cnt_d   = integ_len;
                    div_d   = '0;
                    src_d   = req_hw;
                end
            end
            S_INTEG: begin
                div_d = div_next;
                if (cnt_zero) begin
                    state_d = S_ROG;
                    cnt_d   = ROG_LEN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ROG: begin
                if (cnt_zero) begin
                    state_d = S_READ;
                    cnt_d   = READ_LEN;
                    div_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_READ: begin
                div_d = div_next;
                if (cnt_zero) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    done   = 1'b1;
                    pend_d = 1'b0;
                    if (pend_q || req_any) begin
                        state_d = S_INTEG;
                        cnt_d   = integ_len;
                        div_d   = '0;
                        src_d   = pend_q ? psrc_q : req_hw;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        strobe_d  = (state_d == S_INTEG);
        clk_d     = (state_d == S_INTEG || state_d == S_READ) && (div_d < HALF);
        rog_d     = (state_d == S_ROG);
        start_d   = (state_d == S_READ) && (div_d == '0);
        restart_d = (state_d == S_READ) && (state_q != S_READ);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            pend_q    <= 1'b0;
            psrc_q    <= 1'b0;
            src_q     <= 1'b0;
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
            clk_q     <= 1'b0;
            rog_q     <= 1'b0;
            start_q   <= 1'b0;
            restart_q <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            psrc_q    <= psrc_d;
            src_q     <= src_d;
            busy_q    <= busy_d;
            strobe_q  <= strobe_d;
            clk_q     <= clk_d;
            rog_q     <= rog_d;
            start_q   <= start_d;
            restart_q <= restart_d;
            lost_q    <= lost_d;
        end
    end

    assign busy        = busy_q;
    assign acq_src     = src_q;
    assign strobe_en   = strobe_q;
    assign ccd_clk     = clk_q;
    assign ccd_rog     = rog_q;
    assign adc_start   = start_q;
    assign adc_restart = restart_q;
    assign req_lost    = lost_q;
    assign frame_done  = done;

endmodule

// File: tb/tb_acq_scheduler.sv
// Directed bench for acq_scheduler: frame timing, arbitration, pending/lost
// requests, integration limits, async reset and FIFO drain stall.
module tb_acq_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_sw, req_hw;
    logic [15:0] int_time;
    logic        fifo_empty;
    logic        busy, acq_src, strobe_en, ccd_clk, ccd_rog;
    logic        adc_restart, adc_start, frame_done, req_lost;

    logic        req2;
    logic [15:0] int_time2;
    logic        busy2, src2, strobe2, cclk2, rog2, rst2p, st2p, done2, lost2;

    int checks = 0;
    int failures = 0;

    int n_busy, n_strobe, n_rog, n_start, n_restart, n_done, n_lost, n_clk;
    int n_overlap, n_rst_nostart, n_gap_bad, n_after_done, last_start;
    logic busy0, src_first, src_last, prev_done;
    int nb, nd, cnt2;

    always #5 clk = ~clk;

    acq_scheduler #(
        .PIXELS(16), .CCD_DIV(4), .ROG_CYCLES(8), .INT_UNIT(24)
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .req_sw(req_sw), .req_hw(req_hw),
        .int_time(int_time), .fifo_empty(fifo_empty), .busy(busy),
        .acq_src(acq_src), .strobe_en(strobe_en), .ccd_clk(ccd_clk),
        .ccd_rog(ccd_rog), .adc_restart(adc_restart), .adc_start(adc_start),
        .frame_done(frame_done), .req_lost(req_lost)
    );

    acq_scheduler #(
        .PIXELS(2), .CCD_DIV(2), .ROG_CYCLES(1), .INT_UNIT(1)
    ) dut2 (
        .sys_clk(clk), .sys_rst(rst), .req_sw(1'b0), .req_hw(req2),
        .int_time(int_time2), .fifo_empty(1'b1), .busy(busy2),
        .acq_src(src2), .strobe_en(strobe2), .ccd_clk(cclk2),
        .ccd_rog(rog2), .adc_restart(rst2p), .adc_start(st2p),
        .frame_done(done2), .req_lost(lost2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] outs();
        return {busy, acq_src, strobe_en, ccd_clk, ccd_rog,
                adc_restart, adc_start, frame_done, req_lost};
    endfunction

    // Pulse a request, then observe every cycle until busy falls (bounded).
    task automatic run_frame(input logic sw, input logic hw, input int inj_a,
                             input int inj_b, input int it_at, input logic [15:0] it_new);
        n_busy = 0; n_strobe = 0; n_rog = 0; n_start = 0; n_restart = 0;
        n_done = 0; n_lost = 0; n_clk = 0; n_overlap = 0; n_rst_nostart = 0;
        n_gap_bad = 0; n_after_done = 0; last_start = -1; prev_done = 1'b0;
        req_sw = sw;
        req_hw = hw;
        step();
        req_sw = 1'b0;
        req_hw = 1'b0;
        busy0 = busy;
        src_first = acq_src;
        src_last = acq_src;
        for (int k = 0; k < 5000; k++) begin
            if (!busy) break;
            n_busy++;
            if (strobe_en) n_strobe++;
            if (ccd_rog) n_rog++;
            if (ccd_clk) n_clk++;
            if (ccd_rog && ccd_clk) n_overlap++;
            if (frame_done) n_done++;
            if (req_lost) n_lost++;
            if (adc_restart) begin
                n_restart++;
                last_start = -1;
                if (!adc_start) n_rst_nostart++;
            end
            if (adc_start) begin
                if (last_start >= 0 && k - last_start != 4) n_gap_bad++;
                last_start = k;
                n_start++;
            end
            if (prev_done && strobe_en) n_after_done++;
            prev_done = frame_done;
            src_last = acq_src;
            req_hw = (k == inj_a || k == inj_b);
            if (k == it_at) int_time = it_new;
            step();
        end
        req_hw = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_sw = 1'b0;
        req_hw = 1'b0;
        req2 = 1'b0;
        int_time = 16'd2;
        int_time2 = 16'hFFFF;
        fifo_empty = 1'b1;
        #3;
        chk("reset_outputs", 32'(outs()), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Basic frame; int_time changed mid-integration must be ignored.
        run_frame(1'b1, 1'b0, -1, -1, 5, 16'd5);
        chk("t1_busy_next", 32'(busy0), 32'd1);
        chk("t1_src", 32'(src_first), 32'd0);
        chk("t1_busy_cycles", n_busy, 121);
        chk("t1_strobe", n_strobe, 48);
        chk("t1_rog", n_rog, 8);
        chk("t1_adc_start", n_start, 16);
        chk("t1_restart", n_restart, 1);
        chk("t1_restart_coinc", n_rst_nostart, 0);
        chk("t1_start_gap", n_gap_bad, 0);
        chk("t1_done", n_done, 1);
        chk("t1_ccd_clk_high", n_clk, 56);
        chk("t1_rog_clk_overlap", n_overlap, 0);
        chk("t1_lost", n_lost, 0);
        chk("t1_idle_outs", 32'(outs()), 32'd0);
        int_time = 16'd2;

        run_frame(1'b1, 1'b1, -1, -1, -1, 16'd0);
        chk("t2_src_hw", 32'(src_first), 32'd1);
        chk("t2_done", n_done, 1);
        chk("t2_lost", n_lost, 0);
        chk("t2_busy_cycles", n_busy, 121);

        run_frame(1'b1, 1'b0, 60, 70, -1, 16'd0);
        chk("t3_busy_cycles", n_busy, 242);
        chk("t3_done", n_done, 2);
        chk("t3_lost", n_lost, 1);
        chk("t3_integ_after_done", n_after_done, 1);
        chk("t3_restart", n_restart, 2);
        chk("t3_adc_start", n_start, 32);
        chk("t3_strobe", n_strobe, 96);
        chk("t3_start_gap", n_gap_bad, 0);
        chk("t3_src_first", 32'(src_first), 32'd0);
        chk("t3_src_second", 32'(src_last), 32'd1);

        int_time = 16'd0;
        run_frame(1'b0, 1'b1, -1, -1, -1, 16'd0);
        chk("t4_zero_strobe", n_strobe, 24);
        chk("t4_zero_busy", n_busy, 97);
        int_time = 16'd100;
        run_frame(1'b1, 1'b0, -1, -1, -1, 16'd0);
        chk("t4_100_strobe", n_strobe, 2400);
        chk("t4_100_busy", n_busy, 2473);

        req2 = 1'b1;
        step();
        req2 = 1'b0;
        cnt2 = 0;
        while (strobe2 && cnt2 < 70000) begin
            cnt2++;
            step();
        end
        chk("t4_ffff_strobe", cnt2, 65535);
        repeat (10) step();
        chk("t4_ffff_idle", 32'(busy2), 32'd0);

        // Async reset mid-READ with a pending request stored.
        int_time = 16'd2;
        req_sw = 1'b1;
        step();
        req_sw = 1'b0;
        for (int i = 0; i < 70; i++) begin
            req_hw = (i == 60);
            step();
        end
        req_hw = 1'b0;
        chk("t5_in_read", 32'(busy), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async_outs", 32'(outs()), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("t5_idle_after", 32'(busy), 32'd0);
        run_frame(1'b1, 1'b0, -1, -1, -1, 16'd0);
        chk("t5_busy_cycles", n_busy, 121);
        chk("t5_done", n_done, 1);
        chk("t5_adc_start", n_start, 16);
        chk("t5_src", 32'(src_first), 32'd0);

        // FIFO drain stall.
        fifo_empty = 1'b0;
        req_sw = 1'b1;
        step();
        req_sw = 1'b0;
        repeat (120) step();
        nb = 0;
        nd = 0;
        repeat (100) begin
            if (busy) nb++;
            if (frame_done) nd++;
            step();
        end
        chk("t6_busy_hold", nb, 100);
        chk("t6_no_done", nd, 0);
        fifo_empty = 1'b1;
        #1;
        chk("t6_done", 32'(frame_done), 32'd1);
        step();
        chk("t6_idle", 32'(busy), 32'd0);
        chk("t6_done_clear", 32'(frame_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
